// File: rtl/ecc_mod_pkg.sv
// Shared constants and state encoding for the 257-bit modular add/subtract datapath.
// MODADD_SUB_EN adds the NEGB state used by subtraction.
package ecc_mod_pkg;

  localparam int WIDTH = 257;

  // secp256k1 field prime: 2^256 - 2^32 - 977
  localparam logic [WIDTH-1:0] P_DEFAULT =
    {1'b0, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F};

  function automatic logic [WIDTH-1:0] neg_mod(input logic [WIDTH-1:0] p);
    return ~p + 257'd1;
  endfunction

  localparam logic [WIDTH-1:0] NEG_P = neg_mod(P_DEFAULT);
  localparam logic [WIDTH-1:0] NOT_P = ~P_DEFAULT;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
`ifdef MODADD_SUB_EN
    NEGB = 3'd1,
`endif
    SUM  = 3'd2,
    RED  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/brent_kung_adder257.sv
// 257-bit Brent-Kung parallel-prefix adder producing a 258-bit sum (no carry-in).
module brent_kung_adder257 (
  input  logic [256:0] a,
  input  logic [256:0] b,
  output logic [257:0] sum
);

  localparam int N  = 257;
  localparam int LV = 9;
  localparam int IW = 9;

  logic [N-1:0] prop;
  logic [N-1:0] gg;
  logic [N-1:0] pp;
  logic         hit;
  int           j;

  // Up-sweep then down-sweep prefix tree; gg[i] ends as the carry out of bit i
  always_comb begin
    prop = a ^ b;
    gg   = a & b;
    pp   = prop;
    hit  = 1'b0;
    j    = 0;
    for (int l = 0; l < LV; l++) begin
      for (int i = 0; i < N; i++) begin
        hit = (((i + 1) % (2 << l)) == 0);
        j   = hit ? (i - (1 << l)) : i;
        gg[IW'(i)] = gg[IW'(i)] | (hit & pp[IW'(i)] & gg[IW'(j)]);
        pp[IW'(i)] = pp[IW'(i)] & (~hit | pp[IW'(j)]);
      end
    end
    for (int l = LV - 2; l >= 0; l--) begin
      for (int i = 0; i < N; i++) begin
        hit = ((i + 1) >= (3 << l)) && (((i + 1) % (2 << l)) == (1 << l));
        j   = hit ? (i - (1 << l)) : i;
        gg[IW'(i)] = gg[IW'(i)] | (hit & pp[IW'(i)] & gg[IW'(j)]);
        pp[IW'(i)] = pp[IW'(i)] & (~hit | pp[IW'(j)]);
      end
    end
    sum = {gg[N-1], prop ^ {gg[N-2:0], 1'b0}};
  end

endmodule

// File: rtl/mod_adder257.sv
// Sequential (a +/- b) mod P over one time-shared Brent-Kung adder.
// MODADD_SUB_EN enables subtraction (op honoured, NEGB state and v_r present).
module mod_adder257
  import ecc_mod_pkg::*;
#(
  parameter int               WIDTH = ecc_mod_pkg::WIDTH,
  parameter logic [WIDTH-1:0] P     = P_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] P_NEG = neg_mod(P);
  localparam logic [WIDTH-1:0] P_NOT = ~P;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH:0]   t_r;
  logic [WIDTH-1:0] result_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic [WIDTH:0]   sum;
`ifdef MODADD_SUB_EN
  logic             op_r;
  logic [WIDTH-1:0] v_r;
`else
  logic             unused_op;
  assign unused_op = op;
`endif

  brent_kung_adder257 u_adder (
    .a   (add_x),
    .b   (add_y),
    .sum (sum)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = out_valid_r;
  assign result    = result_r;

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef MODADD_SUB_EN
          next_state = op ? NEGB : SUM;
`else
          next_state = SUM;
`endif
        end else begin
          next_state = IDLE;
        end
      end
`ifdef MODADD_SUB_EN
      NEGB:    next_state = SUM;
`endif
      SUM:     next_state = RED;
      RED:     next_state = DONE;
      DONE:    next_state = out_ready ? IDLE : DONE;
      default: next_state = IDLE;
    endcase
  end

  // Adder operand selection by state; NOT_P turns b into P - b via one's complement
  always_comb begin
    add_x = '0;
    add_y = '0;
    case (state)
`ifdef MODADD_SUB_EN
      NEGB: begin
        add_x = b_r;
        add_y = P_NOT;
      end
      SUM: begin
        add_x = a_r;
        add_y = op_r ? v_r : b_r;
      end
`else
      SUM: begin
        add_x = a_r;
        add_y = b_r;
      end
`endif
      RED: begin
        add_x = t_r[WIDTH-1:0];
        add_y = P_NEG;
      end
      default: begin
        add_x = '0;
        add_y = '0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      t_r         <= '0;
      result_r    <= '0;
      out_valid_r <= 1'b0;
`ifdef MODADD_SUB_EN
      op_r        <= 1'b0;
      v_r         <= '0;
`endif
    end else begin
      state       <= next_state;
      out_valid_r <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r  <= a;
            b_r  <= b;
`ifdef MODADD_SUB_EN
            op_r <= op;
`endif
          end
        end
`ifdef MODADD_SUB_EN
        NEGB: v_r <= ~sum[WIDTH-1:0];
`endif
        SUM:  t_r <= sum;
        // t >= P exactly when t + (2^257 - P) carries, or t already overflowed 257 bits
        RED:  result_r <= (sum[WIDTH] | t_r[WIDTH]) ? sum[WIDTH-1:0] : t_r[WIDTH-1:0];
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_adder257.sv
// Randomized self-checking bench for mod_adder257 against an arithmetic (a +/- b) mod P model.
module tb_mod_adder257;
  import ecc_mod_pkg::*;

  localparam logic [256:0] PM = P_DEFAULT;
`ifdef MODADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [256:0] a;
  logic [256:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [256:0] result;

  int n_checks = 0;
  int n_errors = 0;

  mod_adder257 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [257:0] observed, input logic [257:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [256:0] ref_result(input logic [256:0] x, input logic [256:0] y, input logic sub);
    logic [259:0] acc;
    if (sub && SUB_EN) acc = {3'b000, x} + {3'b000, PM} - {3'b000, y};
    else               acc = {3'b000, x} + {3'b000, y};
    acc = acc % {3'b000, PM};
    return acc[256:0];
  endfunction

  function automatic logic [256:0] rand_operand();
    logic [256:0] v;
    v = {1'b0, $urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
    if (v >= PM) v = v - PM;
    return v;
  endfunction

  task automatic run_op(input logic [256:0] xa, input logic [256:0] xb, input logic xop,
                        input int hold, input string tag);
    int           wait_n;
    int           lat;
    logic [256:0] exp_res;
    exp_res = ref_result(xa, xb, xop);
    wait_n = 0;
    while (!in_ready && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check_value({tag, "_ready"}, {257'd0, in_ready}, 258'd1);
    a = xa; b = xb; op = xop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_value({tag, "_latency"}, 258'(lat), (xop && SUB_EN) ? 258'd4 : 258'd3);
    check_value({tag, "_result"}, {1'b0, result}, {1'b0, exp_res});
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a = rand_operand();
      b = rand_operand();
      @(posedge clk); #1;
      check_value({tag, "_hold_valid"}, {257'd0, out_valid}, 258'd1);
      check_value({tag, "_hold_ready"}, {257'd0, in_ready}, 258'd0);
      check_value({tag, "_hold_result"}, {1'b0, result}, {1'b0, exp_res});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_value({tag, "_drop_valid"}, {257'd0, out_valid}, 258'd0);
    check_value({tag, "_rearm_ready"}, {257'd0, in_ready}, 258'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [256:0] ra;
    logic [256:0] rb;
    logic         seen;
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_value("reset_in_ready", {257'd0, in_ready}, 258'd1);
    check_value("reset_out_valid", {257'd0, out_valid}, 258'd0);
    check_value("reset_result", {1'b0, result}, 258'd0);

    run_op(257'd1, 257'd2, 1'b0, 0, "add_1_2");
    run_op(PM - 257'd1, 257'd1, 1'b0, 0, "add_to_p");
    run_op(PM - 257'd1, PM - 257'd1, 1'b0, 0, "add_max");
    run_op(257'd5, 257'd7, 1'b1, 0, "sub_5_7");
    run_op(257'd9, 257'd9, 1'b1, 0, "sub_equal");
    run_op(257'd0, PM - 257'd1, 1'b1, 0, "sub_0_max");
    run_op(257'd123, 257'd456, 1'b1, 5, "backpressure");

    for (int k = 0; k < 40; k++) begin
      ra = rand_operand();
      rb = (k % 5 == 0) ? ra : rand_operand();
      run_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), "random");
    end

    // abort a request while it sits in the reduction step
    a = 257'd11; b = 257'd22; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_value("abort_in_ready", {257'd0, in_ready}, 258'd1);
    check_value("abort_out_valid", {257'd0, out_valid}, 258'd0);
    check_value("abort_result", {1'b0, result}, 258'd0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_value("abort_no_output", {257'd0, seen}, 258'd0);
    run_op(257'd40, 257'd2, 1'b0, 1, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
